// File: rtl/decode_ctrl_stage.sv
// decode_ctrl_stage: RV32I+M main decoder, D->E control register with
// stall/flush, and a multi-cycle MUL/DIV sequencer that holds the pipeline.
// Optional build macro: ILLEGAL_CHK_EN (flag unknown/reserved encodings in IllegalE).

package decode_ctrl_stage_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MD   = 7'b0000001;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [2:0] RES_ALU  = 3'b000;
    localparam logic [2:0] RES_MEM  = 3'b001;
    localparam logic [2:0] RES_PC4  = 3'b010;
    localparam logic [2:0] RES_PCT  = 3'b011;
    localparam logic [2:0] RES_IMM  = 3'b100;
    localparam logic [2:0] RES_MD   = 3'b101;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Execute-stage control word carried across the D->E boundary
    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic [2:0] result_src;
        logic       alu_src;
        logic [1:0] alu_op;
        logic       branch;
        logic       jump;
        logic       pc_result_src;
        logic [2:0] md_op;
        logic       md_valid;
        logic       illegal;
    } ctrl_e_t;

endpackage

module decode_ctrl_stage
    import decode_ctrl_stage_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = 1,
    parameter int unsigned DIV_CYCLES = 32,
    parameter int unsigned CNT_W      = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       StallE,
    input  logic       FlushE,
    output logic [2:0] ImmSrcD,
    output logic       RegWriteE,
    output logic       MemWriteE,
    output logic [2:0] ResultSrcE,
    output logic       ALUSrcE,
    output logic [1:0] ALUOpE,
    output logic       BranchE,
    output logic       JumpE,
    output logic       PCResultSrcE,
    output logic [2:0] MdOpE,
    output logic       MdValidE,
    output logic       MdDoneE,
    output logic       StallReqD,
    output logic       IllegalE
);

`ifdef ILLEGAL_CHK_EN
    localparam bit ILL_CHK = 1'b1;
`else
    localparam bit ILL_CHK = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_DONE = 2'b10
    } state_t;

    ctrl_e_t          w_dec;
    logic [2:0]       w_imm;
    logic             w_known;
    ctrl_e_t          r_e;
    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_lat;
    logic             w_stall_req;
    logic             w_load;
    logic             w_start;

    // Main decode of the D-stage fields; unknown encodings collapse to a bubble
    always_comb begin
        w_dec            = '0;
        w_dec.result_src = RES_ALU;
        w_dec.alu_op     = ALUOP_ADD;
        w_imm            = IMM_I;
        w_known          = 1'b1;
        case (op)
            OP_LOAD: begin
                w_dec.reg_write  = 1'b1;
                w_dec.alu_src    = 1'b1;
                w_dec.result_src = RES_MEM;
            end
            OP_STORE: begin
                w_imm            = IMM_S;
                w_dec.alu_src    = 1'b1;
                w_dec.mem_write  = 1'b1;
            end
            OP_RTYPE: begin
                if ((funct7 == F7_BASE) ||
                    ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)))) begin
                    w_dec.reg_write = 1'b1;
                    w_dec.alu_op    = ALUOP_FUNCT;
                end else if (funct7 == F7_MD) begin
                    w_dec.reg_write  = 1'b1;
                    w_dec.result_src = RES_MD;
                    w_dec.md_valid   = 1'b1;
                    w_dec.md_op      = funct3;
                end else begin
                    w_known = 1'b0;
                end
            end
            OP_BRANCH: begin
                w_imm            = IMM_B;
                w_dec.branch     = 1'b1;
                w_dec.alu_op     = ALUOP_SUB;
            end
            OP_IALU: begin
                w_dec.reg_write  = 1'b1;
                w_dec.alu_src    = 1'b1;
                w_dec.alu_op     = ALUOP_FUNCT;
            end
            OP_JAL: begin
                w_imm            = IMM_J;
                w_dec.reg_write  = 1'b1;
                w_dec.result_src = RES_PC4;
                w_dec.jump       = 1'b1;
            end
            OP_JALR: begin
                w_dec.reg_write     = 1'b1;
                w_dec.alu_src       = 1'b1;
                w_dec.result_src    = RES_PC4;
                w_dec.jump          = 1'b1;
                w_dec.pc_result_src = 1'b1;
            end
            OP_AUIPC: begin
                w_imm            = IMM_U;
                w_dec.reg_write  = 1'b1;
                w_dec.result_src = RES_PCT;
            end
            OP_LUI: begin
                w_imm            = IMM_U;
                w_dec.reg_write  = 1'b1;
                w_dec.result_src = RES_IMM;
            end
            default: begin
                w_known = 1'b0;
            end
        endcase
        w_dec.illegal = ILL_CHK & ~w_known;
    end

    assign w_stall_req = (r_state == S_BUSY);
    assign w_load      = ~FlushE & ~StallE & ~w_stall_req;
    assign w_start     = w_load & w_dec.md_valid;
    assign w_lat       = funct3[2] ? CNT_W'(DIV_CYCLES - 32'd1) : CNT_W'(MUL_CYCLES - 32'd1);

    // D->E control register: flush beats stall, stall holds, otherwise load
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_e <= '0;
        end else if (FlushE) begin
            r_e <= '0;
        end else if (w_load) begin
            r_e <= w_dec;
        end
    end

    // Sequencer state and latency counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Sequencer next state: count down the M-op latency, abort on flush
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_cnt_nxt   = w_lat;
                    w_state_nxt = (w_lat == '0) ? S_DONE : S_BUSY;
                end
            end
            S_BUSY: begin
                w_cnt_nxt = r_cnt - CNT_W'(1);
                if (r_cnt <= CNT_W'(1)) begin
                    w_state_nxt = S_DONE;
                    w_cnt_nxt   = '0;
                end
            end
            S_DONE: begin
                if (w_start) begin
                    w_cnt_nxt   = w_lat;
                    w_state_nxt = (w_lat == '0) ? S_DONE : S_BUSY;
                end else begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
        if (FlushE) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
        end
    end

    assign ImmSrcD      = w_imm;
    assign StallReqD    = w_stall_req;
    assign MdDoneE      = (r_state == S_DONE) & ~FlushE;
    assign RegWriteE    = r_e.reg_write;
    assign MemWriteE    = r_e.mem_write;
    assign ResultSrcE   = r_e.result_src;
    assign ALUSrcE      = r_e.alu_src;
    assign ALUOpE       = r_e.alu_op;
    assign BranchE      = r_e.branch;
    assign JumpE        = r_e.jump;
    assign PCResultSrcE = r_e.pc_result_src;
    assign MdOpE        = r_e.md_op;
    assign MdValidE     = r_e.md_valid;
    assign IllegalE     = r_e.illegal;

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// Scoreboard bench for decode_ctrl_stage: stimulus pushes hand-computed
// expectations, a monitor pops one per clock (or on async reset) and compares.
module tb_decode_ctrl_stage;

`ifdef ILLEGAL_CHK_EN
    localparam logic ILL = 1'b1;
`else
    localparam logic ILL = 1'b0;
`endif

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_IALU   = 7'b0010011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    // E word field order: rw, mw, rs[2:0], as, aop[1:0], br, j, pcr, mdop[2:0], mdv, ill
    localparam logic [15:0] E_ZERO  = 16'h0000;
    localparam logic [15:0] E_LOAD  = {1'b1,1'b0,3'b001,1'b1,2'b00,1'b0,1'b0,1'b0,3'b000,1'b0,1'b0};
    localparam logic [15:0] E_STORE = {1'b0,1'b1,3'b000,1'b1,2'b00,1'b0,1'b0,1'b0,3'b000,1'b0,1'b0};
    localparam logic [15:0] E_R     = {1'b1,1'b0,3'b000,1'b0,2'b10,1'b0,1'b0,1'b0,3'b000,1'b0,1'b0};
    localparam logic [15:0] E_BR    = {1'b0,1'b0,3'b000,1'b0,2'b01,1'b1,1'b0,1'b0,3'b000,1'b0,1'b0};
    localparam logic [15:0] E_IALU  = {1'b1,1'b0,3'b000,1'b1,2'b10,1'b0,1'b0,1'b0,3'b000,1'b0,1'b0};
    localparam logic [15:0] E_JAL   = {1'b1,1'b0,3'b010,1'b0,2'b00,1'b0,1'b1,1'b0,3'b000,1'b0,1'b0};
    localparam logic [15:0] E_JALR  = {1'b1,1'b0,3'b010,1'b1,2'b00,1'b0,1'b1,1'b1,3'b000,1'b0,1'b0};
    localparam logic [15:0] E_AUIPC = {1'b1,1'b0,3'b011,1'b0,2'b00,1'b0,1'b0,1'b0,3'b000,1'b0,1'b0};
    localparam logic [15:0] E_LUI   = {1'b1,1'b0,3'b100,1'b0,2'b00,1'b0,1'b0,1'b0,3'b000,1'b0,1'b0};
    localparam logic [15:0] E_DIV   = {1'b1,1'b0,3'b101,1'b0,2'b00,1'b0,1'b0,1'b0,3'b100,1'b1,1'b0};
    localparam logic [15:0] E_MUL   = {1'b1,1'b0,3'b101,1'b0,2'b00,1'b0,1'b0,1'b0,3'b000,1'b1,1'b0};
    localparam logic [15:0] E_ILL   = {15'b0, ILL};

    logic       clk;
    logic       reset_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       StallE;
    logic       FlushE;
    logic [2:0] ImmSrcD;
    logic       RegWriteE;
    logic       MemWriteE;
    logic [2:0] ResultSrcE;
    logic       ALUSrcE;
    logic [1:0] ALUOpE;
    logic       BranchE;
    logic       JumpE;
    logic       PCResultSrcE;
    logic [2:0] MdOpE;
    logic       MdValidE;
    logic       MdDoneE;
    logic       StallReqD;
    logic       IllegalE;

    typedef struct {
        string       name;
        logic [20:0] exp;
    } sb_t;

    sb_t q[$];
    int  n_chk  = 0;
    int  n_fail = 0;

    decode_ctrl_stage #(
        .MUL_CYCLES (1),
        .DIV_CYCLES (32),
        .CNT_W      (8)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .op           (op),
        .funct3       (funct3),
        .funct7       (funct7),
        .StallE       (StallE),
        .FlushE       (FlushE),
        .ImmSrcD      (ImmSrcD),
        .RegWriteE    (RegWriteE),
        .MemWriteE    (MemWriteE),
        .ResultSrcE   (ResultSrcE),
        .ALUSrcE      (ALUSrcE),
        .ALUOpE       (ALUOpE),
        .BranchE      (BranchE),
        .JumpE        (JumpE),
        .PCResultSrcE (PCResultSrcE),
        .MdOpE        (MdOpE),
        .MdValidE     (MdValidE),
        .MdDoneE      (MdDoneE),
        .StallReqD    (StallReqD),
        .IllegalE     (IllegalE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [20:0] mk(input logic [2:0] imm, input logic [15:0] e,
                                       input logic done, input logic stall);
        return {imm, e, done, stall};
    endfunction

    // Drive one D-stage instruction at the falling edge and queue the expected
    // outputs as seen just after the following rising edge.
    task automatic step(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                        input logic st, input logic fl, input logic [20:0] ex, input string nm);
        sb_t s;
        @(negedge clk);
        op     = o;
        funct3 = f3;
        funct7 = f7;
        StallE = st;
        FlushE = fl;
        s.name = nm;
        s.exp  = ex;
        q.push_back(s);
    endtask

    task automatic div_load(input string nm);
        step(OPC_R, 3'b100, 7'b0000001, 1'b0, 1'b0, mk(3'b000, E_DIV, 1'b0, 1'b1), nm);
    endtask

    // Stalled cycles with a different instruction waiting in D
    task automatic div_hold(input int n);
        for (int i = 0; i < n; i++)
            step(OPC_LUI, 3'b000, 7'b0, 1'b0, 1'b0, mk(3'b100, E_DIV, 1'b0, 1'b1), "div_busy");
    endtask

    task automatic div_finish();
        step(OPC_LUI, 3'b000, 7'b0, 1'b0, 1'b0, mk(3'b100, E_DIV, 1'b1, 1'b0), "div_done");
        step(OPC_LUI, 3'b000, 7'b0, 1'b0, 1'b0, mk(3'b100, E_LUI, 1'b0, 1'b0), "div_after");
    endtask

    // Monitor: compare the full observable output vector against the queue head
    initial begin
        sb_t         e;
        logic [20:0] obs;
        forever begin
            @(posedge clk or negedge reset_n);
            #1;
            if (q.size() > 0) begin
                e   = q.pop_front();
                obs = {ImmSrcD, RegWriteE, MemWriteE, ResultSrcE, ALUSrcE, ALUOpE, BranchE,
                       JumpE, PCResultSrcE, MdOpE, MdValidE, IllegalE, MdDoneE, StallReqD};
                n_chk++;
                if (obs !== e.exp) begin
                    n_fail++;
                    $display("FAIL %s: actual=%h required=%h", e.name, obs, e.exp);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
        $fatal(1, "timeout");
    end

    initial begin
        sb_t s;
        reset_n = 1'b0;
        op      = 7'b0;
        funct3  = 3'b0;
        funct7  = 7'b0;
        StallE  = 1'b0;
        FlushE  = 1'b0;

        // Reset state
        @(negedge clk);
        s.name = "reset_state";
        s.exp  = mk(3'b000, E_ZERO, 1'b0, 1'b0);
        q.push_back(s);
        @(negedge clk);
        reset_n = 1'b1;

        // Decode sweep
        step(OPC_LOAD,   3'b010, 7'b0,        1'b0, 1'b0, mk(3'b000, E_LOAD,  1'b0, 1'b0), "load");
        step(OPC_STORE,  3'b010, 7'b0,        1'b0, 1'b0, mk(3'b001, E_STORE, 1'b0, 1'b0), "store");
        step(OPC_R,      3'b000, 7'b0000000,  1'b0, 1'b0, mk(3'b000, E_R,     1'b0, 1'b0), "r_add");
        step(OPC_R,      3'b000, 7'b0100000,  1'b0, 1'b0, mk(3'b000, E_R,     1'b0, 1'b0), "r_sub");
        step(OPC_R,      3'b101, 7'b0100000,  1'b0, 1'b0, mk(3'b000, E_R,     1'b0, 1'b0), "r_sra");
        step(OPC_BRANCH, 3'b001, 7'b0,        1'b0, 1'b0, mk(3'b010, E_BR,    1'b0, 1'b0), "branch");
        step(OPC_IALU,   3'b000, 7'b0,        1'b0, 1'b0, mk(3'b000, E_IALU,  1'b0, 1'b0), "ialu");
        step(OPC_JAL,    3'b000, 7'b0,        1'b0, 1'b0, mk(3'b011, E_JAL,   1'b0, 1'b0), "jal");
        step(OPC_JALR,   3'b000, 7'b0,        1'b0, 1'b0, mk(3'b000, E_JALR,  1'b0, 1'b0), "jalr");
        step(OPC_AUIPC,  3'b000, 7'b0,        1'b0, 1'b0, mk(3'b100, E_AUIPC, 1'b0, 1'b0), "auipc");
        step(OPC_LUI,    3'b000, 7'b0,        1'b0, 1'b0, mk(3'b100, E_LUI,   1'b0, 1'b0), "lui");
        step(7'b1111111, 3'b000, 7'b0,        1'b0, 1'b0, mk(3'b000, E_ILL,   1'b0, 1'b0), "illegal_op");
        step(OPC_R,      3'b001, 7'b0100000,  1'b0, 1'b0, mk(3'b000, E_ILL,   1'b0, 1'b0), "illegal_alt_f3");
        step(OPC_R,      3'b000, 7'b1111111,  1'b0, 1'b0, mk(3'b000, E_ILL,   1'b0, 1'b0), "illegal_f7");

        // StallE holds, FlushE beats StallE
        step(OPC_R,   3'b000, 7'b0, 1'b0, 1'b0, mk(3'b000, E_R,    1'b0, 1'b0), "pre_stall");
        step(OPC_LUI, 3'b000, 7'b0, 1'b1, 1'b0, mk(3'b100, E_R,    1'b0, 1'b0), "stall_hold");
        step(OPC_LUI, 3'b000, 7'b0, 1'b1, 1'b1, mk(3'b100, E_ZERO, 1'b0, 1'b0), "flush_over_stall");
        step(OPC_LUI, 3'b000, 7'b0, 1'b0, 1'b0, mk(3'b100, E_LUI,  1'b0, 1'b0), "after_flush");

        // DIV: 31 stall cycles then one done pulse
        div_load("div_load");
        div_hold(30);
        div_finish();

        // MUL (single cycle) immediately followed by a DIV
        step(OPC_R, 3'b000, 7'b0000001, 1'b0, 1'b0, mk(3'b000, E_MUL, 1'b1, 1'b0), "mul_done");
        div_load("div_after_mul");
        div_hold(30);
        div_finish();

        // Flush together with stall while BUSY at cnt=10
        div_load("div_load_flush");
        div_hold(21);
        step(OPC_LUI, 3'b000, 7'b0, 1'b1, 1'b1, mk(3'b100, E_ZERO, 1'b0, 1'b0), "flush_busy");
        for (int i = 0; i < 3; i++)
            step(OPC_R, 3'b000, 7'b0, 1'b0, 1'b0, mk(3'b000, E_R, 1'b0, 1'b0), "post_flush_no_done");

        // Async reset while BUSY at cnt=20
        div_load("div_load_reset");
        div_hold(11);
        @(negedge clk);
        op     = 7'b0;
        funct3 = 3'b0;
        funct7 = 7'b0;
        s.name = "reset_mid_div";
        s.exp  = mk(3'b000, E_ZERO, 1'b0, 1'b0);
        q.push_back(s);
        reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        step(OPC_LOAD, 3'b010, 7'b0, 1'b0, 1'b0, mk(3'b000, E_LOAD, 1'b0, 1'b0), "load_after_reset");
        step(OPC_R,    3'b000, 7'b0, 1'b0, 1'b0, mk(3'b000, E_R,    1'b0, 1'b0), "r_after_reset");

        @(negedge clk);
        @(negedge clk);
        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: actual=%0d pending required=0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_ctrl_stage.md
Name: decode_ctrl_stage

Overview:
- Parametrised main-decode control unit for the RV32I pipeline, extended with the M extension.
- Combinationally decodes the D-stage opcode/funct fields, then registers the execute-stage control word into a D->E pipeline register with stall and flush.
- Contains a multi-cycle sequencer that holds the pipeline while MUL/DIV ops occupy the E stage.
- Sits between the hazard unit and the datapath's D/E boundary.

Parameters:
- MUL_CYCLES, 1, E-stage cycles a MUL/MULH* op occupies (1 = no stall).
- DIV_CYCLES, 32, E-stage cycles a DIV/DIVU/REM/REMU op occupies (range 1..255).
- CNT_W, 8, sequencer counter width; must satisfy 2^CNT_W > max(MUL_CYCLES, DIV_CYCLES).

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- op  in  7  instruction[6:0], D stage.
- funct3  in  3  instruction[14:12], D stage.
- funct7  in  7  instruction[31:25], D stage.
- StallE  in  1  hazard unit: hold the E register.
- FlushE  in  1  hazard unit: load a bubble into the E register.
- ImmSrcD  out  3  combinational: 000 I, 001 S, 010 B, 011 J, 100 U.
- RegWriteE  out  1  registered.
- MemWriteE  out  1  registered.
- ResultSrcE  out  3  registered: 000 ALU, 001 Mem, 010 PC+4, 011 PCTarget, 100 ImmExt, 101 MulDiv.
- ALUSrcE  out  1  registered.
- ALUOpE  out  2  registered: 00 add, 01 sub/compare, 10 funct-decoded.
- BranchE  out  1  registered.
- JumpE  out  1  registered.
- PCResultSrcE  out  1  registered; 1 = jalr target.
- MdOpE  out  3  registered funct3 of the M op, valid when MdValidE = 1.
- MdValidE  out  1  registered; M-op occupies E.
- MdDoneE  out  1  one-cycle pulse; M result valid.
- StallReqD  out  1  request that the hazard unit stall F/D and hold E.
- IllegalE  out  1  registered illegal-instruction flag.

Behaviour:
- Decode (combinational):
  - load: RegWrite=1, ImmSrc=I, ALUSrc=1, ResultSrc=Mem, ALUOp=00.
  - store: ImmSrc=S, ALUSrc=1, MemWrite=1, ALUOp=00.
  - R-type, funct7=0000000/0100000: RegWrite=1, ALUOp=10.
  - R-type, funct7=0000001: RegWrite=1, ResultSrc=MulDiv, MdValid=1.
  - branch: ImmSrc=B, Branch=1, ALUOp=01.
  - I-ALU: RegWrite=1, ImmSrc=I, ALUSrc=1, ALUOp=10.
  - jal: RegWrite=1, ImmSrc=J, ResultSrc=PC+4, Jump=1.
  - jalr: RegWrite=1, ImmSrc=I, ALUSrc=1, ResultSrc=PC+4, Jump=1, PCResultSrc=1.
  - auipc: RegWrite=1, ImmSrc=U, ResultSrc=PCTarget.
  - lui: RegWrite=1, ImmSrc=U, ResultSrc=ImmExt.
  - Every unlisted field is 0; no X outputs.
- E register:
  - Reset: all E outputs 0, MdDoneE=0, StallReqD=0, state IDLE, counter 0.
  - FlushE has priority over StallE. Flush loads the all-zero bubble.
  - StallE or StallReqD holds the register; otherwise it loads the decode word.
- Sequencer (IDLE, BUSY, DONE):
  - IDLE: on the cycle an M op is loaded into E, set cnt = L-1, where L = MUL_CYCLES for funct3[2]=0 and DIV_CYCLES for funct3[2]=1.
    - If L=1, go to DONE the next cycle.
    - Otherwise go to BUSY with StallReqD=1, asserted combinationally from state BUSY.
  - BUSY: decrement cnt every cycle, regardless of StallE. When cnt reaches 1, the next state is DONE.
  - DONE: MdDoneE=1 for exactly one cycle and StallReqD=0. The E register may then advance. Return to IDLE, or re-enter BUSY if a new M op loads the same cycle.
  - FlushE in BUSY or DONE: abort to IDLE, cnt=0, no MdDoneE, E cleared.
  - Async reset mid-operation: immediate return to IDLE with all outputs 0.
- Back-to-back M ops each incur their full latency. No overlap.

Optional Feature:
ILLEGAL_CHK_EN
- Defined:
  - Unknown opcodes set IllegalE=1 in E.
  - R-type with funct7 outside {0000000, 0100000, 0000001} sets IllegalE=1.
  - The 0100000 variant with funct3 other than 000/101 sets IllegalE=1.
  - In all these cases all other controls are 0, so no architectural writes occur.
- Undefined: IllegalE is tied 0 and these cases decode as a silent NOP bubble.

Test Plan:
- Reset: reset_n=0 mid-DIV with cnt=20 -> all outputs 0 immediately. After release, op=0000011 loads RegWriteE=1, ResultSrcE=001, ALUSrcE=1 one cycle later.
- Decode sweep: each of the 9 opcodes with StallE=FlushE=0 -> the E word matches the listed encoding on the next edge, and ImmSrcD matches the same cycle (e.g. lui: ImmSrcD=100, ResultSrcE=100).
- DIV, DIV_CYCLES=32: op=0110011, funct7=0000001, funct3=100 -> StallReqD high for 31 cycles, then MdDoneE pulses once. Total E occupancy 32 cycles.
- MUL, MUL_CYCLES=1, followed by a DIV: MUL gives MdDoneE the cycle after load with no stall. The DIV then stalls 31 cycles.
- FlushE=1 together with StallE=1 during BUSY (cnt=10) -> next cycle all E outputs 0, state IDLE, no MdDoneE ever.
- ILLEGAL_CHK_EN: op=1111111 -> IllegalE=1, RegWriteE=0, MemWriteE=0. With the macro undefined -> IllegalE=0 and all controls 0.
